// File: rtl/rps_pkg.sv
// rps_pkg: move encodings, collector state type, default parameters and popcount helper
package rps_pkg;
  localparam logic [2:0] ROCK = 3'b001;
  localparam logic [2:0] PAPER = 3'b010;
  localparam logic [2:0] SCISSORS = 3'b100;
  localparam int DEF_N_PLAYERS = 2;
  localparam int DEF_MOVE_W = 3;
  localparam int DEF_TIMEOUT = 16;
  localparam int DEF_ERR_W = 8;
  typedef enum logic [1:0] {IDLE, COLLECT, PRESENT} collect_state_t;
  function automatic logic [3:0] popcount8(input logic [7:0] v);
    popcount8 = '0;
    for (int i = 0; i < 8; i++) popcount8 += 4'(v[i]);
  endfunction
endpackage

// File: rtl/move_collect_validator_onehot_check.sv
// onehot_check: flags a move as legal when exactly one bit is set
// ports: move (candidate move), legal (high iff popcount(move) == 1)
module onehot_check #(
  parameter int MOVE_W = 3
) (
  input  logic [MOVE_W-1:0] move,
  output logic              legal
);
  assign legal = (move != '0) && ((move & (move - 1'b1)) == '0);
endmodule

// File: rtl/move_collect_validator.sv
// move_collect_validator: collects one legal one-hot move per player and presents the packed set downstream
// ports: clk/rst (sync, active-high); mv_valid/mv_data/mv_ready per-player input channels;
// mv_reject pulses for rejected moves; out_valid/out_data/out_ready downstream handshake;
// timeout pulses when a round is abandoned; err_count saturating count of rejected moves
module move_collect_validator
  import rps_pkg::*;
#(
  parameter int N_PLAYERS = DEF_N_PLAYERS,
  parameter int MOVE_W = DEF_MOVE_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int ERR_W = DEF_ERR_W
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_PLAYERS-1:0]          mv_valid,
  input  logic [N_PLAYERS*MOVE_W-1:0]   mv_data,
  output logic [N_PLAYERS-1:0]          mv_ready,
  output logic [N_PLAYERS-1:0]          mv_reject,
  output logic                          out_valid,
  output logic [N_PLAYERS*MOVE_W-1:0]   out_data,
  input  logic                          out_ready,
  output logic                          timeout,
  output logic [ERR_W-1:0]              err_count
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam int DW = N_PLAYERS * MOVE_W;
  collect_state_t r_state, w_state_nx;
  logic [N_PLAYERS-1:0] r_latched, r_reject, w_legal, w_hs, w_acc, w_bad, w_mask_nx;
  logic [DW-1:0] r_moves, w_moves_nx;
  logic [TW-1:0] r_timer;
  logic [ERR_W-1:0] r_err;
  logic [ERR_W+3:0] w_err_sum;
  logic r_timeout, w_full, w_expire, w_clear;
  for (genvar p = 0; p < N_PLAYERS; p++) begin : g_chk
    onehot_check #(.MOVE_W(MOVE_W)) u_chk (
      .move (mv_data[p*MOVE_W +: MOVE_W]),
      .legal(w_legal[p])
    );
  end
  assign mv_ready = r_state == PRESENT ? '0 : ~r_latched;
  assign w_hs = mv_valid & mv_ready;
  assign w_acc = w_hs & w_legal;
  assign w_bad = w_hs & ~w_legal;
  assign mv_reject = r_reject;
  assign timeout = r_timeout;
  assign err_count = r_err;
  assign out_valid = r_state == PRESENT;
  assign out_data = out_valid ? r_moves : '0;
  // completion is tested before expiry so a round finishing on its last cycle is presented, not abandoned
  always_comb begin
    w_mask_nx = r_latched | w_acc;
    w_full = &w_mask_nx;
    w_expire = TIMEOUT != 0 && r_state == COLLECT && !w_full && r_timer == TW'(TIMEOUT - 1);
    w_clear = w_expire || (r_state == PRESENT && out_ready);
    w_state_nx = r_state == PRESENT ? (out_ready ? IDLE : PRESENT)
               : w_full ? PRESENT
               : w_expire ? IDLE
               : (r_state == COLLECT || |w_acc) ? COLLECT : IDLE;
    w_moves_nx = r_moves;
    for (int i = 0; i < N_PLAYERS; i++)
      if (w_acc[i]) w_moves_nx[i*MOVE_W +: MOVE_W] = mv_data[i*MOVE_W +: MOVE_W];
    w_err_sum = (ERR_W+4)'(r_err) + (ERR_W+4)'(popcount8(8'(w_bad)));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_latched <= '0;
      r_moves <= '0;
      r_timer <= '0;
      r_reject <= '0;
      r_timeout <= 1'b0;
      r_err <= '0;
    end else begin
      r_state <= w_state_nx;
      r_latched <= w_clear ? '0 : w_mask_nx;
      r_moves <= w_clear ? '0 : w_moves_nx;
      r_timer <= (r_state == COLLECT && w_state_nx == COLLECT) ? r_timer + 1'b1 : '0;
      r_reject <= w_bad;
      r_timeout <= w_expire;
      r_err <= |w_err_sum[ERR_W+3:ERR_W] ? '1 : w_err_sum[ERR_W-1:0];
    end
  end
endmodule

// File: tb/tb_move_collect_validator.sv
// tb_move_collect_validator: scoreboard bench with an event-level reference model of the move collector
module tb_move_collect_validator;
  import rps_pkg::*;
  localparam int N = 2;
  localparam int W = 3;
  localparam int TO = 16;
  localparam int EW = 8;
  localparam int EMAX = (1 << EW) - 1;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic out_ready = 1'b1;
  logic [N-1:0] mv_valid = '0;
  logic [N-1:0] mv_ready, mv_reject;
  logic [N*W-1:0] mv_data = '0;
  logic [N*W-1:0] out_data;
  logic out_valid, timeout;
  logic [EW-1:0] err_count;
  always #5 clk = ~clk;
  move_collect_validator #(.N_PLAYERS(N), .MOVE_W(W), .TIMEOUT(TO), .ERR_W(EW)) dut (
    .clk(clk), .rst(rst), .mv_valid(mv_valid), .mv_data(mv_data), .mv_ready(mv_ready),
    .mv_reject(mv_reject), .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .timeout(timeout), .err_count(err_count)
  );
  typedef struct { int stamp; logic [N*W-1:0] v; } ev_t;
  ev_t out_q[$];
  ev_t rej_q[$];
  ev_t to_q[$];
  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;
  int start = 0;
  int errs = 0;
  logic [N-1:0] held = '0;
  logic [N*W-1:0] moves = '0;
  bit presenting = 1'b0;
  bit started = 1'b0;
  bit prev_ov = 1'b0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask
  // reference model: applies one clock edge of the round rules to the inputs sampled at that edge
  task automatic model_step();
    logic [N-1:0] bad;
    logic [W-1:0] mv;
    bit was_coll;
    int nb;
    cyc++;
    if (rst) begin
      held = '0; moves = '0; presenting = 1'b0; errs = 0;
      out_q.delete(); rej_q.delete(); to_q.delete();
    end else if (presenting) begin
      if (out_ready) begin presenting = 1'b0; held = '0; moves = '0; end
    end else begin
      was_coll = held != '0;
      bad = '0;
      for (int p = 0; p < N; p++)
        if (mv_valid[p] && !held[p]) begin
          mv = mv_data[p*W +: W];
          if ($countones(mv) == 1) begin held[p] = 1'b1; moves[p*W +: W] = mv; end
          else bad[p] = 1'b1;
        end
      nb = $countones(bad);
      errs = (errs + nb > EMAX) ? EMAX : errs + nb;
      if (bad != '0) rej_q.push_back(ev_t'{cyc, (N*W)'(bad)});
      if (&held) begin
        presenting = 1'b1;
        out_q.push_back(ev_t'{cyc, moves});
      end else if (held != '0 && !was_coll) start = cyc;
      else if (was_coll && TO != 0 && cyc - start == TO) begin
        to_q.push_back(ev_t'{cyc, '0});
        held = '0; moves = '0;
      end
    end
  endtask
  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask
  task automatic drive(input logic [N-1:0] v, input logic [N*W-1:0] d, input logic r);
    mv_valid = v; mv_data = d; out_ready = r;
    tick();
  endtask
  always @(negedge clk) if (started) begin
    logic [N-1:0] exp_rdy, exp_rej;
    bit exp_to;
    exp_rdy = presenting ? '0 : ~held;
    chk("mv_ready", 64'(mv_ready), 64'(exp_rdy));
    chk("out_valid", 64'(out_valid), 64'(presenting));
    chk("err_count", 64'(err_count), 64'(errs));
    if (!presenting && held == '0) chk("out_data_idle", 64'(out_data), 64'(0));
    exp_rej = '0;
    if (rej_q.size() != 0 && rej_q[0].stamp == cyc) exp_rej = N'(rej_q.pop_front().v);
    chk("mv_reject", 64'(mv_reject), 64'(exp_rej));
    exp_to = 1'b0;
    if (to_q.size() != 0 && to_q[0].stamp == cyc) begin exp_to = 1'b1; void'(to_q.pop_front()); end
    chk("timeout", 64'(timeout), 64'(exp_to));
    if (out_valid && !prev_ov) begin
      chk("out_expected", 64'(out_q.size()), 64'(1));
      if (out_q.size() != 0) chk("out_latency", 64'(cyc), 64'(out_q[0].stamp));
    end
    if (out_valid && out_ready && out_q.size() != 0) begin
      chk("out_data", 64'(out_data), 64'(out_q[0].v));
      void'(out_q.pop_front());
    end
    prev_ov = out_valid;
  end
  initial begin
    tick();
    tick();
    rst = 1'b0;
    started = 1'b1;
    drive('0, '0, 1'b1);
    // A then B one cycle apart
    drive(2'b01, {3'b000, ROCK}, 1'b1);
    drive(2'b10, {SCISSORS, 3'b000}, 1'b1);
    repeat (3) drive('0, '0, 1'b1);
    // simultaneous illegal moves, then a legal pair
    drive(2'b11, {3'b000, 3'b011}, 1'b1);
    drive('0, '0, 1'b1);
    drive(2'b11, {PAPER, PAPER}, 1'b1);
    repeat (3) drive('0, '0, 1'b1);
    // lone player times out, then a fresh round from the other player
    drive(2'b01, {3'b000, ROCK}, 1'b1);
    repeat (20) drive('0, '0, 1'b1);
    drive(2'b10, {SCISSORS, 3'b000}, 1'b1);
    repeat (20) drive('0, '0, 1'b1);
    // completion on the expiry cycle
    drive(2'b01, {3'b000, ROCK}, 1'b1);
    repeat (15) drive('0, '0, 1'b1);
    drive(2'b10, {SCISSORS, 3'b000}, 1'b1);
    repeat (3) drive('0, '0, 1'b1);
    // stalled downstream while players keep driving
    drive(2'b11, {PAPER, ROCK}, 1'b0);
    repeat (5) drive(2'b11, {3'b111, PAPER}, 1'b0);
    drive('0, '0, 1'b1);
    repeat (2) drive('0, '0, 1'b1);
    repeat (400) begin
      rst = $urandom_range(0, 199) == 0;
      drive(N'($urandom & $urandom), (N*W)'($urandom), $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    repeat (5) drive('0, '0, 1'b1);
    // saturate the error counter, then reset in the middle of a presentation
    repeat (130) drive(2'b11, {3'b111, 3'b011}, 1'b1);
    drive(2'b11, {SCISSORS, PAPER}, 1'b0);
    drive('0, '0, 1'b0);
    rst = 1'b1;
    drive('0, '0, 1'b0);
    rst = 1'b0;
    @(negedge clk);
    #1;
    chk("rst_err_count", 64'(err_count), 64'(0));
    chk("rst_out_valid", 64'(out_valid), 64'(0));
    chk("rst_out_data", 64'(out_data), 64'(0));
    chk("rst_mv_ready", 64'(mv_ready), 64'(2'b11));
    repeat (300) begin
      rst = $urandom_range(0, 299) == 0;
      drive(N'($urandom & $urandom), (N*W)'($urandom), $urandom_range(0, 3) != 0);
    end
    rst = 1'b0;
    repeat (30) drive('0, '0, 1'b1);
    @(negedge clk);
    #1;
    chk("out_q_drained", 64'(out_q.size()), 64'(0));
    chk("rej_q_drained", 64'(rej_q.size()), 64'(0));
    chk("to_q_drained", 64'(to_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/move_collect_validator.md
Name: move_collect_validator

Overview:
- Parametrised, sequential successor to the combinational two-player move check.
- Collects one one-hot move per player over independent valid/ready channels, rejects malformed moves and lets the player retry.
- When every player holds a legal move, presents the packed move set downstream with a valid/ready handshake.
- Sits between player input capture and the round scorer; adds a round timeout and a saturating error counter.

Parameters:
- N_PLAYERS, 2, number of player channels (2..8).
- MOVE_W, 3, move width in bits; a legal move has exactly one bit set.
- TIMEOUT, 16, max cycles in COLLECT before the round is abandoned; 0 disables the timeout.
- ERR_W, 8, width of the saturating invalid-move counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- mv_valid  in  N_PLAYERS  per-player move-present.
- mv_data  in  N_PLAYERS*MOVE_W  packed moves; player p occupies bits [p*MOVE_W +: MOVE_W].
- mv_ready  out  N_PLAYERS  per-player accept.
- mv_reject  out  N_PLAYERS  one-cycle pulse: the accepted move was not one-hot.
- out_valid  out  1  complete legal move set available.
- out_data  out  N_PLAYERS*MOVE_W  latched moves, same packing as mv_data.
- out_ready  in  1  downstream accept.
- timeout  out  1  one-cycle pulse: round abandoned.
- err_count  out  ERR_W  saturating count of rejected moves.

Behaviour:
- Reset values: state IDLE, mv_ready all 1, mv_reject 0, out_valid 0, out_data 0, timeout 0, err_count 0, latched mask 0, timer 0.
- Reset has priority over all events, including an in-flight round or a pending out_valid. Everything clears next edge.
- Legality: move legal iff popcount == 1. This rejects all-zero, all-ones and any multi-bit pattern.
- mv_ready[p] = (state != PRESENT) && !latched[p]. It is combinational from registered state only, with no dependence on mv_valid.
- Handshake for player p = mv_valid[p] & mv_ready[p].
  - Legal move: latched[p] is set and the move is stored.
  - Illegal move: nothing is latched; mv_reject[p] = 1 on the next cycle; err_count += 1.
- Simultaneous illegal handshakes add their popcount to err_count in one cycle. err_count saturates at 2^ERR_W-1 and never wraps.
- States:
  - IDLE: timer held at 0. Any legal handshake goes to COLLECT, or to PRESENT if that cycle completes the latched mask.
  - COLLECT: timer increments each cycle. If the latched mask becomes all-ones, go to PRESENT. Otherwise, if TIMEOUT != 0 and the timer reaches TIMEOUT-1, pulse timeout next cycle, clear the mask and stored moves, and go to IDLE.
  - PRESENT: out_valid = 1, out_data stable, all mv_ready = 0. When out_ready = 1, go to IDLE next cycle with mask cleared. out_data returns to 0 in IDLE.
- Latency: out_valid rises on the cycle after the completing handshake. No combinational path exists from mv_* to out_*.
- Simultaneous events:
  - Completion and timeout expiry in the same cycle: completion wins, no timeout pulse.
  - Illegal move from another player in the same cycle: still rejected and counted.
- A latched player re-driving mv_valid is ignored (ready is low), with no reject and no count.
- An illegal move does not start the timer in IDLE.
- TIMEOUT = 0: COLLECT waits indefinitely.
- Back-to-back rounds: a new round's moves can be accepted from the cycle after out_valid&out_ready.

Decomposition:
- rps_pkg holds:
  - move encodings ROCK = 3'b001, PAPER = 3'b010, SCISSORS = 3'b100 for MOVE_W = 3;
  - the state typedef collect_state_t {IDLE, COLLECT, PRESENT};
  - default parameter constants.
- One sub-module: onehot_check, parametrised by MOVE_W, combinational, output legal. Instantiate it once per player in a generate loop.

Test Plan:
- N=2, A=001 then B=100 one cycle apart, out_ready=1 -> out_valid one cycle after the B handshake, out_data=6'b100_001, back to IDLE, mv_ready=2'b11.
- A=011, B=000 same cycle -> mv_reject=2'b11 next cycle, err_count=2, state stays IDLE, nothing latched; then A=010, B=010 -> out_data=6'b010_010.
- TIMEOUT=16, A=001 only -> timeout pulses exactly once, 16 cycles after entering COLLECT, mask cleared; a later B=100 alone starts a fresh round.
- B completes on the same cycle the timer hits TIMEOUT-1 -> out_valid=1, timeout stays 0.
- out_ready held low for 5 cycles in PRESENT while both players drive new moves -> mv_ready=0, out_data unchanged, no reject, err_count unchanged.
- ERR_W=2, 5 illegal moves -> err_count saturates at 3; rst asserted mid-PRESENT -> all outputs return to reset values next cycle.
